mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width.
REQ-002 clk  input  1  pipeline clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  EX stage issues op this cycle.
REQ-005 op  input  3  md_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 rs_data  input  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
REQ-007 rt_data  input  WIDTH  multiplier/divisor.
REQ-008 mf_req  input  1  MFHI/MFLO currently in EX.
REQ-009 flush  input  1  abort any in-flight operation.
REQ-010 hi  output  WIDTH  HI register.
REQ-011 lo  output  WIDTH  LO register.
REQ-012 busy  output  1  iterative operation in progress.
REQ-013 done  output  1  one-cycle pulse when HI/LO written by MULT/DIV.
REQ-014 stall  output  1  hold IF/ID/EX; equals busy & (mf_req | start).

Function
REQ-015 FSM states IDLE, MUL, DIV, FIX; IDLE on reset.
REQ-016 IDLE: start & MULT/MULTU -> MUL; start & DIV/DIVU -> DIV; latch |operands| (signed ops) or raw (unsigned ops), record result signs.
REQ-017 MUL: shift-add, one bit/cycle, 32 cycles, 64-bit product.
REQ-018 DIV: restoring division, one quotient bit/cycle, 32 cycles.
REQ-019 After last iteration -> FIX (one cycle): apply signs; FIX -> IDLE writes {hi,lo} and pulses done.
REQ-020 Latency: start at edge N; busy high N+1..N+33; hi/lo valid and done high after edge N+34.
REQ-021 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with dividend's sign.
REQ-023 Divide by zero: full latency; lo = all ones, hi = rs_data.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-025 MTHI/MTLO when idle: hi/lo written at next edge; busy and done stay low.
REQ-026 start while busy: ignored; stall high; upstream re-presents it after busy falls.
REQ-027 mf_req while busy: stall high until busy falls; hi/lo readable same cycle busy is low.
REQ-028 flush: FSM -> IDLE next edge; hi/lo unchanged; no done; flush priority over start same cycle.
REQ-029 FIX and flush same cycle: flush wins, hi/lo not written.

Reset
REQ-030 rst low: immediately state IDLE, hi = 0, lo = 0, busy = 0, done = 0, stall = 0, datapath registers 0.
REQ-031 Reset mid-operation discards operation; no done after release.

Configuration
REQ-032 MDU_FAST_MUL_EN defined: MULT/MULTU use a single-cycle combinational multiplier: IDLE -> FIX -> IDLE; hi/lo valid after edge N+2; busy high only at N+1.
REQ-033 MDU_FAST_MUL_EN undefined: iterative multiply per REQ-017/020; divide always iterative.

Structure
REQ-034 Package mdu_pkg: md_op_t enum, md_state_t enum, ITER_CNT = 32 constant.
REQ-035 One sub-module mdu_div_step: single restoring-division step (remainder, quotient bit), combinational.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 cycles hi = 0xFFFFFFFE, lo = 0x00000001, done pulse.
REQ-037 MULT -3 x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; with MDU_FAST_MUL_EN same values after 2 cycles.
REQ-038 DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 100.
REQ-039 mf_req at cycle 5 of DIV -> stall high until busy falls; second start during op ignored.
REQ-040 flush at cycle 10 of MULT with hi = 0x1234 from prior MTHI -> IDLE, hi = 0x1234, no done.
REQ-041 rst low at cycle 20 of DIVU -> outputs 0 immediately; new MULT after release completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit (mdu).
//   md_op_t    : operation code presented on mdu.op
//   md_state_t : mdu control FSM states
//   ITER_CNT   : iterations of the shift-add / restoring-divide loops
package mdu_pkg;

  localparam int unsigned ITER_CNT = 32;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } md_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step, purely combinational.
//   rem_i      : partial remainder entering the step (always < divisor_i)
//   bit_i      : next dividend bit shifted into the remainder
//   divisor_i  : divisor magnitude
//   rem_o      : partial remainder after the trial subtraction
//   q_bit_o    : quotient bit produced by this step
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    // The true difference is below 2^WIDTH, so dropping the top bit is exact.
    rem_o   = q_bit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers for an in-order pipeline.
// Multiply is shift-add and divide is restoring, one bit per cycle, on operand
// magnitudes; signs are applied in a final FIX cycle before HI/LO are written.
// Optional build macro: MDU_FAST_MUL_EN selects a single-cycle multiplier for
// MULT/MULTU (IDLE -> FIX -> IDLE); divide is always iterative.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start, op     : EX issues an md_op_t this cycle
//   rs_data       : multiplicand / dividend / MTHI-MTLO source
//   rt_data       : multiplier / divisor
//   mf_req        : MFHI/MFLO sitting in EX
//   flush         : abort any in-flight operation
//   hi, lo        : architectural HI/LO
//   busy          : iterative operation in progress
//   done          : one-cycle pulse after HI/LO written by a MULT/DIV
//   stall         : hold IF/ID/EX (busy & (mf_req | start))
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mf_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CntW = $clog2(ITER_CNT);

  md_state_t          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // acc: {partial product high, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;    // product or quotient negative
  logic               rneg_q, rneg_d;  // remainder negative
  logic               mul_q, mul_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  md_op_t             op_e;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot_res, rem_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  assign op_e      = md_op_t'(op);
  assign signed_op = (op_e == OpMult) || (op_e == OpDiv);
  assign a_neg     = signed_op & rs_data[WIDTH-1];
  assign b_neg     = signed_op & rt_data[WIDTH-1];
  assign a_abs     = a_neg ? (~rs_data + 1'b1) : rs_data;
  assign b_abs     = b_neg ? (~rt_data + 1'b1) : rt_data;

  // Shift-add: add multiplicand when the current multiplier bit is set, then
  // shift the whole accumulator right (carry enters the top).
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i    (acc_q[WIDTH-1]),
    .divisor_i(opb_q),
    .rem_o    (rem_next),
    .q_bit_o  (q_bit)
  );

`ifdef MDU_FAST_MUL_EN
  assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

  assign mul_res  = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quot_res = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_res  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mul_d   = mul_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op_e)
              OpMult, OpMultu: begin
                opb_d = a_abs;
                neg_d = a_neg ^ b_neg;
                mul_d = 1'b1;
                cnt_d = '0;
`ifdef MDU_FAST_MUL_EN
                acc_d   = fast_prod;
                state_d = StFix;
`else
                acc_d   = {{WIDTH{1'b0}}, b_abs};
                state_d = StMul;
`endif
              end
              OpDiv, OpDivu: begin
                acc_d   = {{WIDTH{1'b0}}, a_abs};
                opb_d   = b_abs;
                // Divide by zero yields an all-ones quotient, never negated.
                neg_d   = (a_neg ^ b_neg) & (rt_data != '0);
                rneg_d  = a_neg;
                mul_d   = 1'b0;
                cnt_d   = '0;
                state_d = StDiv;
              end
              OpMthi:  hi_d = rs_data;
              OpMtlo:  lo_d = rs_data;
              default: ;
            endcase
          end
        end
        StMul: begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER_CNT - 1)) state_d = StFix;
        end
        StDiv: begin
          acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER_CNT - 1)) state_d = StFix;
        end
        StFix: begin
          if (mul_q) begin
            {hi_d, lo_d} = mul_res;
          end else begin
            hi_d = rem_res;
            lo_d = quot_res;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mul_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mul_q   <= mul_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign stall = busy & (mf_req | start);

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu. Inputs change and outputs are sampled
// 1 time unit after the rising edge; latencies are counted in edges after the
// edge that samples start.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        mf_req, flush;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  mdu #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .mf_req (mf_req),
    .flush  (flush),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; returns 1 unit after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    tick();
    start = 1'b0;
    op    = OpNone;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Count done pulses over a window; used where no completion may occur.
  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int lat;
    issue(o, a, b);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic stall_ok;

    rst = 1'b0; start = 1'b0; op = OpNone; rs_data = '0; rt_data = '0;
    mf_req = 1'b0; flush = 1'b0;
    #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Moves to HI/LO are single-edge and never raise busy or done.
    issue(OpMthi, 32'h0000_1234, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    issue(OpMtlo, 32'h0000_ABCD, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'hABCD);

    run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat);
    run_op("mult_m3x7", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulLat);
    run_op("mult_min2", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MulLat);
    run_op("mult_neg1", OpMult, 32'd12345, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7, MulLat);
    run_op("div_m7d2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat);
    run_op("div_7dm2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, DivLat);
    run_op("divu_dz", OpDivu, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DivLat);
    run_op("div_dz_neg", OpDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DivLat);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivLat);
    run_op("divu_max3", OpDivu, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h5555_5555, DivLat);
    run_op("divu_1000", OpDivu, 32'd1000, 32'd7, 32'd6, 32'd142, DivLat);

    // MFHI waiting on a divide, plus a second start that must be ignored.
    issue(OpDiv, 32'd100, 32'd7);
    repeat (3) tick();
    mf_req = 1'b1;
    start = 1'b1; op = OpMult; rs_data = 32'd3; rt_data = 32'd3;
    #1;
    chk("mf_start_stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0; op = OpNone;
    stall_ok = 1'b1;
    lat = -1;
    for (int j = 5; j <= 100; j++) begin
      if (busy !== 1'b1 || stall !== 1'b1) stall_ok = 1'b0;
      tick();
      if (done === 1'b1) begin
        lat = j;
        break;
      end
    end
    chk("mf_stall_held", 64'(stall_ok), 64'd1);
    chk("mf_lat", 64'(lat), 64'(DivLat));
    chk("mf_stall_drop", 64'(stall), 64'd0);
    chk("mf_hi", 64'(hi), 64'd2);
    chk("mf_lo", 64'(lo), 64'd14);
    mf_req = 1'b0;
    tick();
    chk("ignored_start", 64'(busy), 64'd0);

    // Flush during a multiply leaves HI/LO alone and produces no done.
    issue(OpMthi, 32'h0000_1234, 32'h0);
    issue(OpMtlo, 32'h0000_ABCD, 32'h0);
    issue(OpMult, 32'd5, 32'd6);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h1234);
    chk("flush_lo", 64'(lo), 64'hABCD);
    count_done(40, seen);
    chk("flush_no_done", 64'(seen), 64'd0);

    // Flush beats a same-cycle start.
    flush = 1'b1; start = 1'b1; op = OpMult; rs_data = 32'd2; rt_data = 32'd2;
    tick();
    flush = 1'b0; start = 1'b0; op = OpNone;
    chk("flush_start_busy", 64'(busy), 64'd0);

    // Flush in the FIX cycle blocks the HI/LO write.
    issue(OpDiv, 32'd100, 32'd7);
    repeat (32) tick();
    chk("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fix_flush_done", 64'(done), 64'd0);
    chk("fix_flush_hi", 64'(hi), 64'h1234);
    chk("fix_flush_lo", 64'(lo), 64'hABCD);
    count_done(5, seen);
    chk("fix_flush_no_done", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a divide.
    issue(OpDivu, 32'd1000, 32'd7);
    repeat (19) tick();
    mf_req = 1'b1;
    #1;
    chk("pre_rst_stall", 64'(stall), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b1;
    mf_req = 1'b0;
    count_done(40, seen);
    chk("arst_no_done", 64'(seen), 64'd0);
    run_op("post_rst_mult", OpMult, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, MulLat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
